// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: default widths,
// requester port indices and the arbitration FSM state encoding.
package mem_arb_pkg;

  localparam int DEFAULT_AW = 8;
  localparam int DEFAULT_DW = 8;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and a shared memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int AW = DEFAULT_AW,
  parameter int DW = DEFAULT_DW
) ();

  logic          p0_req;
  logic          p0_we;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata;
  logic          p0_ack;
  logic [DW-1:0] p0_rdata;

  logic          p1_req;
  logic          p1_we;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata;
  logic          p1_ack;
  logic [DW-1:0] p1_rdata;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p0_ack, p0_rdata, p1_ack, p1_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p0_ack, p0_rdata, p1_ack, p1_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, on a tie the port
// that was not served last wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  // Grant index from the request vector and the last-served pointer
  always_comb begin
    grant = PORT0;
    if (req == 2'b11) begin
      grant = ~last;
    end else if (req[1]) begin
      grant = PORT1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter onto a single-ported combinational-read memory.
// Each access walks IDLE -> SETUP -> ACCESS -> RESP so the address is held
// one cycle either side of the write strobe; results are per-port registered.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = DEFAULT_AW,
  parameter int DW = DEFAULT_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  state_t        state;
  logic          winner;
  logic          last_served;
  logic          we_q;
  logic          mem_we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;
  logic          ack0_q;
  logic          ack1_q;

  logic [1:0]    req_vec;
  logic          grant;
  logic [DW-1:0] result;

  assign req_vec = {bus.p1_req, bus.p0_req};

  // A write echoes its own data back; a read takes the memory output
  assign result = we_q ? wdata_q : bus.mem_rdata;

  rr_arb2 u_pick (
    .req   (req_vec),
    .last  (last_served),
    .grant (grant)
  );

  // Arbitration FSM with all bus outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      winner      <= PORT0;
      last_served <= PORT1;
      we_q        <= 1'b0;
      mem_we_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_vec) begin
            winner <= grant;
            if (grant == PORT1) begin
              addr_q  <= bus.p1_addr;
              we_q    <= bus.p1_we;
              wdata_q <= bus.p1_wdata;
            end else begin
              addr_q  <= bus.p0_addr;
              we_q    <= bus.p0_we;
              wdata_q <= bus.p0_wdata;
            end
            state <= SETUP;
          end
        end
        SETUP: begin
          mem_we_q <= we_q;
          state    <= ACCESS;
        end
        ACCESS: begin
          mem_we_q <= 1'b0;
          if (winner == PORT1) begin
            rdata1_q <= result;
            ack1_q   <= 1'b1;
          end else begin
            rdata0_q <= result;
            ack0_q   <= 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          ack0_q      <= 1'b0;
          ack1_q      <= 1'b0;
          last_served <= winner;
          state       <= IDLE;
        end
        default: begin
          mem_we_q <= 1'b0;
          ack0_q   <= 1'b0;
          ack1_q   <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.p0_ack    = ack0_q;
  assign bus.p1_ack    = ack1_q;
  assign bus.p0_rdata  = rdata0_q;
  assign bus.p1_rdata  = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a table of single accesses plus
// hand-written tie, back-to-back and reset-mid-write sequences, with a
// scoreboard of expected (port, rdata) pairs popped on every ack.
module tb_mem_arbiter;

  typedef struct {
    int         port;
    logic [7:0] rdata;
  } exp_t;

  typedef struct {
    int         port;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  logic clk;
  logic rst_n;

  logic [7:0] mem [256];

  exp_t sbq[$];
  vec_t vecs[11];

  int checks;
  int failures;
  int we_count;
  logic [7:0] we_addr;
  logic [7:0] we_data;

  mem_arbiter_if #(.AW(8), .DW(8)) bus ();

  mem_arbiter #(.AW(8), .DW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Combinational-read memory model
  assign bus.mem_rdata = mem[bus.mem_addr];

  // Memory write port
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: every ack pops one expectation; also tracks strobes
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.p0_ack && bus.p1_ack) begin
        check_output("ack_exclusive", 32'd2, 32'd1);
      end else if (bus.p0_ack || bus.p1_ack) begin
        if (sbq.size() == 0) begin
          check_output("spurious_ack", {31'd0, bus.p1_ack}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check_output("sb_ack_port", bus.p1_ack ? 32'd1 : 32'd0, e.port);
          check_output("sb_rdata", bus.p1_ack ? bus.p1_rdata : bus.p0_rdata, e.rdata);
        end
      end
      if (bus.mem_we) begin
        we_count++;
        we_addr = bus.mem_addr;
        we_data = bus.mem_wdata;
      end
    end
  end

  function automatic logic ack_of(input int port);
    return (port == 1) ? bus.p1_ack : bus.p0_ack;
  endfunction

  task automatic drive_port(input int port, input logic req, input logic we,
                            input logic [7:0] addr, input logic [7:0] wdata);
    if (port == 1) begin
      bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata;
    end else begin
      bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata;
    end
  endtask

  task automatic wait_ack(input int port, input int max_cycles,
                          output int cycles, output bit ok);
    ok = 1'b0;
    cycles = 0;
    for (int i = 1; i <= max_cycles; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack_of(port)) begin
        cycles = i;
        ok = 1'b1;
        return;
      end
    end
  endtask

  // One complete access on one port; called and returns at a falling edge
  task automatic apply_stimulus(input int port, input logic we, input logic [7:0] addr,
                                input logic [7:0] wdata, input logic [7:0] exp_rdata);
    logic [7:0] other_before;
    int cyc;
    bit ok;
    exp_t e;
    e.port = port;
    e.rdata = exp_rdata;
    sbq.push_back(e);
    we_count = 0;
    other_before = (port == 1) ? bus.p0_rdata : bus.p1_rdata;
    drive_port(port, 1'b1, we, addr, wdata);
    wait_ack(port, 8, cyc, ok);
    check_output("ack_seen", {31'd0, ok}, 32'd1);
    if (ok) check_output("ack_latency", cyc, 32'd3);
    drive_port(port, 1'b0, 1'b0, 8'h00, 8'h00);
    check_output("we_pulses", we_count, we ? 32'd1 : 32'd0);
    if (we) begin
      check_output("we_addr", {24'd0, we_addr}, {24'd0, addr});
      check_output("we_data", {24'd0, we_data}, {24'd0, wdata});
    end
    check_output("other_rdata_kept", (port == 1) ? bus.p0_rdata : bus.p1_rdata, other_before);
    @(negedge clk);
  endtask

  task automatic check_all_zero();
    check_output("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check_output("rst_mem_addr", {24'd0, bus.mem_addr}, 32'd0);
    check_output("rst_mem_wdata", {24'd0, bus.mem_wdata}, 32'd0);
    check_output("rst_p0_ack", {31'd0, bus.p0_ack}, 32'd0);
    check_output("rst_p1_ack", {31'd0, bus.p1_ack}, 32'd0);
    check_output("rst_p0_rdata", {24'd0, bus.p0_rdata}, 32'd0);
    check_output("rst_p1_rdata", {24'd0, bus.p1_rdata}, 32'd0);
  endtask

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence
  initial begin
    int p0_acks;
    int ack_cyc[3];
    int n;
    int idle_acks;
    logic [7:0] p1_before;
    exp_t e;

    checks = 0;
    failures = 0;
    we_count = 0;
    we_addr = 8'h00;
    we_data = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = i[7:0] ^ 8'h33;
    mem[8'h10] = 8'hA5;

    vecs[0]  = '{port: 0, we: 1'b0, addr: 8'h10, wdata: 8'h00, exp_rdata: 8'hA5};
    vecs[1]  = '{port: 1, we: 1'b1, addr: 8'hFF, wdata: 8'h3C, exp_rdata: 8'h3C};
    vecs[2]  = '{port: 1, we: 1'b0, addr: 8'hFF, wdata: 8'h00, exp_rdata: 8'h3C};
    vecs[3]  = '{port: 0, we: 1'b1, addr: 8'h00, wdata: 8'hFF, exp_rdata: 8'hFF};
    vecs[4]  = '{port: 1, we: 1'b1, addr: 8'hFF, wdata: 8'h00, exp_rdata: 8'h00};
    vecs[5]  = '{port: 0, we: 1'b0, addr: 8'h00, wdata: 8'h00, exp_rdata: 8'hFF};
    vecs[6]  = '{port: 1, we: 1'b0, addr: 8'hFF, wdata: 8'h00, exp_rdata: 8'h00};
    vecs[7]  = '{port: 0, we: 1'b1, addr: 8'h80, wdata: 8'h5A, exp_rdata: 8'h5A};
    vecs[8]  = '{port: 1, we: 1'b0, addr: 8'h80, wdata: 8'h00, exp_rdata: 8'h5A};
    vecs[9]  = '{port: 0, we: 1'b0, addr: 8'h7F, wdata: 8'h00, exp_rdata: 8'h4C};
    vecs[10] = '{port: 1, we: 1'b0, addr: 8'h00, wdata: 8'h00, exp_rdata: 8'hFF};

    rst_n = 1'b0;
    drive_port(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive_port(1, 1'b0, 1'b0, 8'h00, 8'h00);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_all_zero();
    rst_n = 1'b1;
    @(negedge clk);

    // Tie after reset, both held: p0 at +3, p1 wins the next tie at +7, p0 at +11
    $display("[TB] tie sequence");
    e.port = 0; e.rdata = 8'h13; sbq.push_back(e);
    e.port = 1; e.rdata = 8'h12; sbq.push_back(e);
    e.port = 0; e.rdata = 8'h13; sbq.push_back(e);
    drive_port(0, 1'b1, 1'b0, 8'h20, 8'h00);
    drive_port(1, 1'b1, 1'b0, 8'h21, 8'h00);
    p0_acks = 0;
    ack_cyc[0] = 0; ack_cyc[1] = 0; ack_cyc[2] = 0;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.p0_ack) begin
        if (p0_acks == 0) ack_cyc[0] = c; else ack_cyc[2] = c;
        p0_acks++;
        if (p0_acks == 2) drive_port(0, 1'b0, 1'b0, 8'h00, 8'h00);
      end
      if (bus.p1_ack) begin
        ack_cyc[1] = c;
        drive_port(1, 1'b0, 1'b0, 8'h00, 8'h00);
      end
      if (!bus.p0_req && !bus.p1_req) break;
    end
    drive_port(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive_port(1, 1'b0, 1'b0, 8'h00, 8'h00);
    check_output("tie_p0_first", ack_cyc[0], 32'd3);
    check_output("tie_p1_next", ack_cyc[1], 32'd7);
    check_output("tie_p0_again", ack_cyc[2], 32'd11);
    @(negedge clk);

    // Table of single accesses
    $display("[TB] table vectors");
    for (int i = 0; i < 11; i++) begin
      apply_stimulus(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
    end

    // Back-to-back reads on p0 with req held high
    $display("[TB] back-to-back sequence");
    p1_before = bus.p1_rdata;
    we_count = 0;
    e.port = 0; e.rdata = 8'h73; sbq.push_back(e);
    e.port = 0; e.rdata = 8'h72; sbq.push_back(e);
    e.port = 0; e.rdata = 8'h71; sbq.push_back(e);
    drive_port(0, 1'b1, 1'b0, 8'h40, 8'h00);
    n = 0;
    ack_cyc[0] = 0; ack_cyc[1] = 0; ack_cyc[2] = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.p0_ack) begin
        ack_cyc[n] = c;
        n++;
        if (n < 3) drive_port(0, 1'b1, 1'b0, 8'h40 + 8'(n), 8'h00);
        else begin
          drive_port(0, 1'b0, 1'b0, 8'h00, 8'h00);
          break;
        end
      end
    end
    drive_port(0, 1'b0, 1'b0, 8'h00, 8'h00);
    check_output("b2b_acks", n, 32'd3);
    check_output("b2b_first", ack_cyc[0], 32'd3);
    check_output("b2b_gap1", ack_cyc[1] - ack_cyc[0], 32'd4);
    check_output("b2b_gap2", ack_cyc[2] - ack_cyc[1], 32'd4);
    check_output("b2b_p1_rdata", {24'd0, bus.p1_rdata}, {24'd0, p1_before});
    check_output("b2b_no_we", we_count, 32'd0);
    @(negedge clk);

    // Reset during the ACCESS cycle of a write
    $display("[TB] reset mid-write sequence");
    drive_port(1, 1'b1, 1'b1, 8'h90, 8'h55);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_output("mw_we_high", {31'd0, bus.mem_we}, 32'd1);
    #1 rst_n = 1'b0;
    drive_port(1, 1'b0, 1'b0, 8'h00, 8'h00);
    #1 check_output("mw_we_async_low", {31'd0, bus.mem_we}, 32'd0);
    check_all_zero();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_acks = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.p0_ack || bus.p1_ack) idle_acks++;
    end
    check_output("mw_no_ack", idle_acks, 32'd0);

    // The abandoned write must not have reached memory
    apply_stimulus(0, 1'b0, 8'h90, 8'h00, 8'hA3);

    check_output("sb_drained", sbq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
